// File: rtl/masked_state_serializer_pkg.sv
// Shared constants and types for the masked state serializer:
// default geometry, buffer width helper and FSM encoding.
package masked_state_serializer_pkg;

  localparam int DEF_NBITS     = 4;
  localparam int DEF_MAX_WORDS = 8;
  localparam int DEF_SHARES    = 2;
  localparam int DEF_WORD_W    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Flat width of one full masked state (all shares, all buffer slots).
  function automatic int buf_w(input int shares, input int words, input int word_w);
    return shares * words * word_w;
  endfunction

endpackage

// File: rtl/share_word_tx_counter.sv
// Share-major word/share index counters for the serializer output.
// Word index rolls to 0 and bumps the share index after the bound word.
module share_word_tx_counter
  import masked_state_serializer_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [NBITS-1:0] bound,
  output logic [NBITS-1:0] share_idx,
  output logic [NBITS-1:0] word_idx,
  output logic             last_word
);

  assign last_word = (word_idx == bound);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      share_idx <= '0;
      word_idx  <= '0;
    end else if (clr) begin
      share_idx <= '0;
      word_idx  <= '0;
    end else if (inc) begin
      if (last_word) begin
        word_idx  <= '0;
        share_idx <= share_idx + 1'b1;
      end else begin
        word_idx  <= word_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/masked_state_serializer.sv
// Serializes one parallel masked state into share-major word beats.
// Share data is only visible on out_data during a valid beat.
module masked_state_serializer
  import masked_state_serializer_pkg::*;
#(
  parameter int NBITS               = DEF_NBITS,
  parameter int MAX_WORDS_PER_SHARE = DEF_MAX_WORDS,
  parameter int d                   = DEF_SHARES,
  parameter int WORD_W              = DEF_WORD_W
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [buf_w(d, MAX_WORDS_PER_SHARE, WORD_W)-1:0] in_data,
  input  logic [NBITS-1:0]                                words_per_share_bound,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [WORD_W-1:0]                               out_data,
  output logic [NBITS-1:0]                                out_share_idx,
  output logic [NBITS-1:0]                                out_word_idx,
  output logic                                            out_last_word,
  output logic                                            out_last
);

  localparam int NW   = d * MAX_WORDS_PER_SHARE;
  localparam int SELW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [NBITS-1:0] MAX_IDX    = NBITS'(MAX_WORDS_PER_SHARE - 1);
  localparam logic [NBITS-1:0] LAST_SHARE = NBITS'(d - 1);

  logic [NW-1:0][WORD_W-1:0] buf_q;
  state_e                    state;
  logic                      alive;
  logic [NBITS-1:0]          bound_q;
  logic [NBITS-1:0]          bound_clamp;
  logic [NBITS-1:0]          share_idx;
  logic [NBITS-1:0]          word_idx;
  logic                      last_word;
  logic                      last_raw;
  logic                      load;
  logic                      beat;
  logic [SELW-1:0]           sel;

  assign bound_clamp = (words_per_share_bound > MAX_IDX) ? MAX_IDX : words_per_share_bound;

  assign out_valid = (state == SEND);
  assign last_raw  = last_word && (share_idx == LAST_SHARE);
  // alive keeps in_ready low through reset and until the first edge after release.
  assign in_ready  = alive && (!out_valid || (last_raw && out_ready));
  assign load      = in_valid && in_ready;
  assign beat      = out_valid && out_ready;

  share_word_tx_counter #(
    .NBITS(NBITS)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (load || (beat && last_raw)),
    .inc       (beat && !last_raw),
    .bound     (bound_q),
    .share_idx (share_idx),
    .word_idx  (word_idx),
    .last_word (last_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bound_q <= '0;
      alive   <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (load) begin
        state   <= SEND;
        bound_q <= bound_clamp;
      end else if (beat && last_raw) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) buf_q <= in_data;
  end

  assign sel = SELW'(share_idx) * SELW'(MAX_WORDS_PER_SHARE) + SELW'(word_idx);

  assign out_data      = out_valid ? buf_q[sel] : '0;
  assign out_last_word = out_valid && last_word;
  assign out_last      = out_valid && last_raw;
  assign out_share_idx = share_idx;
  assign out_word_idx  = word_idx;

endmodule

// File: tb/tb_masked_state_serializer.sv
// Scoreboard bench: driver pushes expected beats from a share-major model,
// monitor pops and compares on every presented word.
module tb_masked_state_serializer;
  import masked_state_serializer_pkg::*;

  localparam int NBITS = 4;
  localparam int MWS   = 8;
  localparam int D     = 2;
  localparam int WW    = 32;
  localparam int BW    = D * MWS * WW;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [BW-1:0]    in_data;
  logic [NBITS-1:0] words_per_share_bound;
  logic             out_valid;
  logic             out_ready;
  logic [WW-1:0]    out_data;
  logic [NBITS-1:0] out_share_idx;
  logic [NBITS-1:0] out_word_idx;
  logic             out_last_word;
  logic             out_last;

  masked_state_serializer #(
    .NBITS(NBITS), .MAX_WORDS_PER_SHARE(MWS), .d(D), .WORD_W(WW)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_data               (in_data),
    .words_per_share_bound (words_per_share_bound),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_data              (out_data),
    .out_share_idx         (out_share_idx),
    .out_word_idx          (out_word_idx),
    .out_last_word         (out_last_word),
    .out_last              (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0]    data;
    logic [NBITS-1:0] s;
    logic [NBITS-1:0] w;
    logic             lw;
    logic             l;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   mode   = 0;
  bit   tog    = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: words per share = min(bound, MWS-1)+1, emitted share-major.
  task automatic model_push(input logic [BW-1:0] data, input logic [NBITS-1:0] b);
    int   bc;
    exp_t e;
    bc = (int'(b) > MWS - 1) ? MWS - 1 : int'(b);
    for (int s = 0; s < D; s++)
      for (int w = 0; w <= bc; w++) begin
        e.data = data[(s * MWS + w) * WW +: WW];
        e.s    = NBITS'(s);
        e.w    = NBITS'(w);
        e.lw   = (w == bc);
        e.l    = (w == bc) && (s == D - 1);
        q.push_back(e);
      end
  endtask

  task automatic drive_ready();
    case (mode)
      0:       out_ready = 1'b1;
      1:       begin out_ready = tog; tog = !tog; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      drive_ready();
      words_per_share_bound = NBITS'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called just after a negedge; returns at the negedge after acceptance.
  task automatic present(input logic [BW-1:0] data, input logic [NBITS-1:0] b, output bit busy);
    bit acc;
    acc  = 1'b0;
    busy = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    words_per_share_bound = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      drive_ready();
      #1;
      if (in_ready) begin
        acc  = 1'b1;
        busy = out_valid;
        model_push(data, b);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    words_per_share_bound = NBITS'($urandom);
    if (!acc) begin
      n_chk++;
      $display("FAIL load_timeout: got no in_ready expected accept within 200 cycles");
    end else chk("first_word_latency", out_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && !(q.size() == 0 && !out_valid); i++) cycles(1);
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_idle", out_valid, 0);
  endtask

  function automatic logic [BW-1:0] rand_state();
    logic [BW-1:0] v;
    for (int i = 0; i < D * MWS; i++) v[i * WW +: WW] = $urandom;
    return v;
  endfunction

  // Monitor: samples 1 time unit before each rising edge.
  initial begin : monitor
    exp_t          e;
    int            since_rst;
    bit            prev_stall;
    logic [WW-1:0] prev_data;
    since_rst  = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        since_rst  = 0;
        prev_stall = 1'b0;
      end else begin
        since_rst++;
        if (!out_valid) begin
          chk("idle_data_gated", out_data, 0);
          chk("idle_last_gated", {out_last_word, out_last}, 0);
          if (since_rst >= 2) chk("in_ready_idle", in_ready, 1);
        end else if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got word %0h at (%0d,%0d) expected none",
                   out_data, out_share_idx, out_word_idx);
        end else begin
          e = q[0];
          chk("beat_data", out_data, e.data);
          chk("beat_share_idx", out_share_idx, e.s);
          chk("beat_word_idx", out_word_idx, e.w);
          chk("beat_last_word", out_last_word, e.lw);
          chk("beat_last", out_last, e.l);
          chk("in_ready_send", in_ready, e.l && out_ready);
          if (prev_stall) chk("stall_hold_data", out_data, prev_data);
          if (out_ready) void'(q.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [BW-1:0] d1;
    bit            busy;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    words_per_share_bound = '0;
    for (int s = 0; s < D; s++)
      for (int w = 0; w < MWS; w++) d1[(s * MWS + w) * WW +: WW] = WW'(s * 16 + w);

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_indices", {out_share_idx, out_word_idx}, 0);
    chk("rst_last", {out_last_word, out_last}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    chk("in_ready_after_reset", in_ready, 1);

    // Full throughput, bound 3.
    mode = 0;
    present(d1, 4'd3, busy);
    drain();

    // Alternating ready: stalls must hold the presented word.
    mode = 1; tog = 1'b1;
    present(d1, 4'd3, busy);
    drain();

    // One word per share.
    mode = 0;
    present(rand_state(), 4'd0, busy);
    drain();

    // Back-to-back: second state accepted on the final beat of the first.
    present(rand_state(), 4'd3, busy);
    present(rand_state(), 4'd2, busy);
    chk("b2b_accept_on_final_beat", busy, 1);
    drain();

    // Oversized bound clamps; bound input is scrambled during the transfer.
    mode = 2;
    present(rand_state(), 4'd15, busy);
    drain();

    for (int i = 0; i < 6; i++) begin
      mode = int'($urandom_range(0, 2));
      present(rand_state(), NBITS'($urandom), busy);
      if ($urandom_range(0, 1) == 1) present(rand_state(), NBITS'($urandom), busy);
      else cycles(int'($urandom_range(0, 3)));
    end
    drain();

    // Reset in the middle of a transfer.
    mode = 0;
    present(rand_state(), 4'd3, busy);
    cycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    chk("midrst_in_ready_release", in_ready, 1);
    chk("midrst_indices_cleared", {out_share_idx, out_word_idx}, 0);
    present(rand_state(), 4'd1, busy);
    drain();

    chk("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
